mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
- MEM-stage load/store sequencer that sits between the 5-cycle MIPS pipeline and the word-addressed data memory.
- The memory has a 32-bit combinational read, a whole-word write on the clock negedge, and word index addr[11:2]. This block turns pipeline byte, halfword and word loads/stores into word accesses.
- Partial stores use read-modify-write. Load data is extracted and extended here. Misaligned accesses are flagged.

Parameters:
- ADDR_W, 32, width of the request address, exception address and memory address.

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  reset reset, asynchronous, active-high.
- req_valid  in  1  request strobe; sampled only when busy=0.
- req_we  in  1  1=store, 0=load.
- req_size  in  2  00=byte, 01=half, 10=word; 11 is treated as word.
- req_unsigned  in  1  loads only: zero-extend when 1, sign-extend when 0.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  32  store data, right-justified.
- busy  out  1  high while state is not IDLE; pipeline stalls MEM on busy.
- resp_valid  out  1  one-cycle pulse when a request completes.
- load_data  out  32  extended load result; valid with resp_valid; 0 for stores.
- misalign_exc  out  1  qualifies resp_valid: request was misaligned.
- exc_addr  out  ADDR_W  offending req_addr; valid with misalign_exc.
- mem_addr  out  ADDR_W  word-aligned address to memory; 0 in IDLE.
- mem_rdata  in  32  combinational memory read data.
- mem_wdata  out  32  word to write.
- mem_write  out  1  memory write enable.

Behaviour:
- Byte order is little-endian: lane n = addr[1:0] = n occupies bits [8n+7:8n].
- Alignment: half requires addr[0]=0; word requires addr[1:0]=00.
- FSM states: IDLE, RD, WR.
  - Accept means IDLE and req_valid. On accept, latch addr, size, unsigned, we and wdata.
- Load, aligned: IDLE -> RD.
  - In RD, mem_addr = {addr[ADDR_W-1:2],00}.
  - Lane-select and extend mem_rdata into load_data register.
  - Return to IDLE with resp_valid=1 in the next cycle.
  - Latency: accept at cycle N, resp at N+2.
- Store word, aligned: IDLE -> WR.
  - In WR, mem_write=1 and mem_wdata = wdata.
  - Back to IDLE; resp_valid at N+2.
- Store byte/half, aligned: IDLE -> RD -> WR.
  - RD captures mem_rdata.
  - WR writes the captured word with the target lane(s) replaced by wdata[7:0] or wdata[15:0].
  - resp_valid at N+3.
- mem_write is high for exactly one cycle per store, and only in WR. It is never high for loads.
- Misaligned request (feature enabled):
  - No memory access; FSM stays IDLE and busy stays 0.
  - At N+1: resp_valid=1, misalign_exc=1, exc_addr=req_addr, load_data=0.
- busy is combinational from state. req_valid while busy=1 is ignored, not queued.
- A new request may be accepted in the same cycle resp_valid is high, since the FSM is in IDLE.
- Reset values: state=IDLE, busy=0, resp_valid=0, misalign_exc=0, exc_addr=0, load_data=0, mem_addr=0, mem_wdata=0, mem_write=0.
- Reset mid-operation:
  - Outputs clear immediately (async) and the in-flight request is dropped with no response.
  - Reset asserted in WR before the clock negedge suppresses the write.
- Load sign extension uses bit 7 (byte) or bit 15 (half) of the selected lane.

Optional Feature:
- Macro MISALIGN_TRAP_EN.
- Defined: misaligned requests trap as described above.
- Undefined:
  - No trap; misalign_exc and exc_addr are tied to 0.
  - Misaligned half addresses force addr[0]=0.
  - Misaligned word addresses force addr[1:0]=00.
  - The access then proceeds normally with identical latency.

Test Plan:
- Setup: mem[0x10]=0xA1B2C3D4.
- LB at 0x11 -> load_data=0xFFFFFFC3, resp_valid at N+2, busy high exactly 1 cycle.
- LBU at 0x13 -> 0x000000A1. LHU at 0x12 -> 0x0000A1B2. LW at 0x10 -> 0xA1B2C3D4.
- SH at 0x12 with wdata 0x12345566 -> mem[0x10]=0x5566C3D4; one mem_write pulse, in WR at N+2; resp_valid at N+3. A follow-up LW at 0x10 returns 0x5566C3D4.
- LW at 0x16 with MISALIGN_TRAP_EN -> resp_valid+misalign_exc at N+1, exc_addr=0x16, busy=0, no mem_write. Without the macro -> load_data=mem[0x14].
- SB at 0x10 (wdata 0xEE), reset asserted during RD -> busy=0 and resp_valid=0 immediately, no mem_write ever, mem[0x10] unchanged.
- Back-to-back: LW issued while busy is ignored. LW issued the cycle resp_valid is high is accepted, with its resp two cycles later.

Source files
------------

// File: rtl/mem_access_if.sv
// mem_access_if: pipeline request/response and data-memory signals of mem_access_unit
interface mem_access_if #(parameter int ADDR_W = 32);
    logic              req_valid;
    logic              req_we;
    logic [1:0]        req_size;
    logic              req_unsigned;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              busy;
    logic              resp_valid;
    logic [31:0]       load_data;
    logic              misalign_exc;
    logic [ADDR_W-1:0] exc_addr;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_rdata;
    logic [31:0]       mem_wdata;
    logic              mem_write;
    modport master(
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, mem_rdata,
        input  busy, resp_valid, load_data, misalign_exc, exc_addr, mem_addr, mem_wdata, mem_write
    );
    modport slave(
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, mem_rdata,
        output busy, resp_valid, load_data, misalign_exc, exc_addr, mem_addr, mem_wdata, mem_write
    );
endinterface

// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage load/store sequencer with read-modify-write partial stores; MISALIGN_TRAP_EN enables misalignment traps
module mem_access_unit #(parameter int ADDR_W = 32) (
    input  logic        clk,
    input  logic        reset,
    mem_access_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RD, WR} state_t;
    state_t            state, state_nx;
    logic [ADDR_W-1:0] a, eff_addr, exc_r;
    logic [1:0]        sz;
    logic              uns, we, mis, accept, resp_r, exc_v;
    logic [31:0]       wd, rw, ld_r, ext, mask, merged;
    logic [15:0]       lane;
    logic [4:0]        sh;

    assign accept = state == IDLE && bus.req_valid;
`ifdef MISALIGN_TRAP_EN
    assign mis = bus.req_size == 2'b01 ? bus.req_addr[0] : bus.req_size[1] ? |bus.req_addr[1:0] : 1'b0;
    assign eff_addr = bus.req_addr;
`else
    assign mis = 1'b0;
    assign eff_addr = bus.req_size == 2'b01 ? {bus.req_addr[ADDR_W-1:1], 1'b0} :
                      bus.req_size[1] ? {bus.req_addr[ADDR_W-1:2], 2'b00} : bus.req_addr;
`endif
    assign sh = {a[1:0], 3'b000};
    assign lane = 16'(bus.mem_rdata >> sh);
    assign ext = sz == 2'b00 ? {{24{~uns & lane[7]}}, lane[7:0]} :
                 sz == 2'b01 ? {{16{~uns & lane[15]}}, lane} : bus.mem_rdata;
    assign mask = (sz == 2'b00 ? 32'h0000_00ff : 32'h0000_ffff) << sh;
    assign merged = (rw & ~mask) | ((wd << sh) & mask);

    assign bus.busy = state != IDLE;
    assign bus.mem_write = state == WR;
    assign bus.mem_addr = state == IDLE ? '0 : {a[ADDR_W-1:2], 2'b00};
    assign bus.mem_wdata = state != WR ? 32'h0 : sz[1] ? wd : merged;
    assign bus.resp_valid = resp_r;
    assign bus.misalign_exc = exc_v;
    assign bus.exc_addr = exc_r;
    assign bus.load_data = ld_r;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else state <= state_nx;
    end

    // Next state: word stores skip the read, partial stores read then write
    always_comb begin
        state_nx = state;
        if (state == IDLE) state_nx = accept && !mis ? (bus.req_we && bus.req_size[1] ? WR : RD) : IDLE;
        else if (state == RD) state_nx = we ? WR : IDLE;
        else state_nx = IDLE;
    end

    // Request latch, read-word capture and registered response
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a <= '0;
            sz <= '0;
            uns <= 1'b0;
            we <= 1'b0;
            wd <= '0;
            rw <= '0;
            resp_r <= 1'b0;
            exc_v <= 1'b0;
            exc_r <= '0;
            ld_r <= '0;
        end else begin
            resp_r <= 1'b0;
            exc_v <= 1'b0;
            if (accept) begin
                a <= eff_addr;
                sz <= bus.req_size;
                uns <= bus.req_unsigned;
                we <= bus.req_we;
                wd <= bus.req_wdata;
                if (mis) begin
                    resp_r <= 1'b1;
                    exc_v <= 1'b1;
                    exc_r <= bus.req_addr;
                    ld_r <= '0;
                end
            end
            if (state == RD) begin
                rw <= bus.mem_rdata;
                if (!we) begin
                    resp_r <= 1'b1;
                    ld_r <= ext;
                end
            end
            if (state == WR) begin
                resp_r <= 1'b1;
                ld_r <= '0;
            end
        end
    end
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed tests of mem_access_unit against a byte-level reference model
module tb_mem_access_unit;
`ifdef MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif
    logic clk = 1'b0;
    logic reset = 1'b1;
    mem_access_if #(.ADDR_W(32)) bus();
    mem_access_unit #(.ADDR_W(32)) dut(.clk(clk), .reset(reset), .bus(bus));
    always #5 clk = ~clk;

    logic [31:0] dmem [0:1023];
    logic [7:0]  mm [0:4095];
    bit          exp_busy [0:1023];
    bit          exp_resp [0:1023];
    bit          exp_exc [0:1023];
    bit          exp_wr [0:1023];
    logic [31:0] exp_ld [0:1023];
    logic [31:0] exp_ea [0:1023];
    logic [31:0] exp_wa [0:1023];
    int cyc = 0, checks = 0, errors = 0, free_edge = 0, acc_edge = 0, got_edge = 0;
    int n_resp = 0, n_busy = 0, n_wr = 0;
    logic [31:0] got_ld = 0, got_ea = 0;
    logic got_exc = 0;
    bit run = 0;

    assign bus.mem_rdata = dmem[bus.mem_addr[11:2]];
    always @(negedge clk) if (bus.mem_write) dmem[bus.mem_addr[11:2]] <= bus.mem_wdata;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %h expected %h", nm, cyc, act, exp);
        end
    endtask

    // Per-cycle comparison of DUT outputs against the model's expectation tables
    always @(posedge clk) begin
        #1;
        if (run && !reset) begin
            chk("busy", 32'(bus.busy), 32'(exp_busy[cyc]));
            chk("resp_valid", 32'(bus.resp_valid), 32'(exp_resp[cyc]));
            chk("mem_write", 32'(bus.mem_write), 32'(exp_wr[cyc]));
            if (exp_wr[cyc]) chk("mem_addr", bus.mem_addr, exp_wa[cyc]);
            if (exp_resp[cyc]) begin
                chk("load_data", bus.load_data, exp_ld[cyc]);
                chk("misalign_exc", 32'(bus.misalign_exc), 32'(exp_exc[cyc]));
                if (exp_exc[cyc]) chk("exc_addr", bus.exc_addr, exp_ea[cyc]);
            end
            n_busy += int'(bus.busy);
            n_wr += int'(bus.mem_write);
            if (bus.resp_valid) begin
                n_resp++;
                got_edge = cyc;
                got_ld = bus.load_data;
                got_exc = bus.misalign_exc;
                got_ea = bus.exc_addr;
            end
        end
    end

    // Drive one request for one cycle and record what the memory semantics demand
    task automatic issue(input bit w, input logic [1:0] s, input bit u, input logic [31:0] ad, input logic [31:0] d);
        int p, nb, lat, base;
        logic [31:0] v;
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_we = w;
        bus.req_size = s;
        bus.req_unsigned = u;
        bus.req_addr = ad;
        bus.req_wdata = d;
        p = cyc + 1;
        nb = s == 2'b00 ? 1 : s == 2'b01 ? 2 : 4;
        if (p >= free_edge) begin
            acc_edge = p;
            if (TRAP && int'(ad[1:0]) % nb != 0) begin
                exp_resp[p] = 1;
                exp_exc[p] = 1;
                exp_ea[p] = ad;
                exp_ld[p] = 0;
                free_edge = p + 1;
            end else begin
                base = int'(ad[11:0]) - int'(ad[1:0]) % nb;
                v = 0;
                if (!w) begin
                    for (int i = 0; i < nb; i++) v |= 32'(mm[base + i]) << (8 * i);
                    if (!u && nb < 4 && v[8 * nb - 1]) v |= 32'hFFFF_FFFF << (8 * nb);
                    lat = 2;
                end else begin
                    for (int i = 0; i < nb; i++) mm[base + i] = 8'(d >> (8 * i));
                    lat = nb == 4 ? 2 : 3;
                    exp_wr[p + lat - 2] = 1;
                    exp_wa[p + lat - 2] = 32'(base) & ~32'h3;
                end
                for (int k = p; k <= p + lat - 2; k++) exp_busy[k] = 1;
                exp_resp[p + lat - 1] = 1;
                exp_exc[p + lat - 1] = 0;
                exp_ld[p + lat - 1] = v;
                free_edge = p + lat;
            end
        end
        @(posedge clk);
        #2 bus.req_valid = 1'b0;
    endtask

    initial begin
        int b0, w0, r0;
        logic [7:0] sv;
        bus.req_valid = 0;
        bus.req_we = 0;
        bus.req_size = 0;
        bus.req_unsigned = 0;
        bus.req_addr = 0;
        bus.req_wdata = 0;
        for (int i = 0; i < 1024; i++) dmem[i] = 0;
        for (int i = 0; i < 4096; i++) mm[i] = 0;
        dmem[4] = 32'hA1B2C3D4;
        dmem[5] = 32'h0BADF00D;
        mm[16] = 8'hD4; mm[17] = 8'hC3; mm[18] = 8'hB2; mm[19] = 8'hA1;
        mm[20] = 8'h0D; mm[21] = 8'hF0; mm[22] = 8'hAD; mm[23] = 8'h0B;
        #12;
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_resp_valid", 32'(bus.resp_valid), 0);
        chk("rst_misalign_exc", 32'(bus.misalign_exc), 0);
        chk("rst_exc_addr", bus.exc_addr, 0);
        chk("rst_load_data", bus.load_data, 0);
        chk("rst_mem_addr", bus.mem_addr, 0);
        chk("rst_mem_wdata", bus.mem_wdata, 0);
        chk("rst_mem_write", 32'(bus.mem_write), 0);
        @(negedge clk);
        reset = 0;
        run = 1;

        b0 = n_busy;
        issue(0, 2'b00, 0, 32'h11, 0); repeat (3) @(negedge clk);
        chk("lb_data", got_ld, 32'hFFFFFFC3);
        chk("lb_latency", 32'(got_edge - acc_edge + 1), 2);
        chk("lb_busy_cycles", 32'(n_busy - b0), 1);
        issue(0, 2'b00, 1, 32'h13, 0); repeat (3) @(negedge clk);
        chk("lbu_data", got_ld, 32'h000000A1);
        issue(0, 2'b01, 1, 32'h12, 0); repeat (3) @(negedge clk);
        chk("lhu_data", got_ld, 32'h0000A1B2);
        issue(0, 2'b10, 0, 32'h10, 0); repeat (3) @(negedge clk);
        chk("lw_data", got_ld, 32'hA1B2C3D4);

        w0 = n_wr;
        issue(1, 2'b01, 0, 32'h12, 32'h12345566); repeat (4) @(negedge clk);
        chk("sh_mem", dmem[4], 32'h5566C3D4);
        chk("sh_latency", 32'(got_edge - acc_edge + 1), 3);
        chk("sh_write_pulses", 32'(n_wr - w0), 1);
        issue(0, 2'b10, 0, 32'h10, 0); repeat (3) @(negedge clk);
        chk("lw_after_sh", got_ld, 32'h5566C3D4);

        b0 = n_busy; w0 = n_wr;
        issue(0, 2'b10, 0, 32'h16, 0); repeat (3) @(negedge clk);
`ifdef MISALIGN_TRAP_EN
        chk("mis_exc", 32'(got_exc), 1);
        chk("mis_exc_addr", got_ea, 32'h16);
        chk("mis_latency", 32'(got_edge - acc_edge + 1), 1);
        chk("mis_busy_cycles", 32'(n_busy - b0), 0);
        chk("mis_write_pulses", 32'(n_wr - w0), 0);
`else
        chk("mis_forced_data", got_ld, 32'h0BADF00D);
        chk("mis_forced_exc", 32'(got_exc), 0);
`endif
        issue(0, 2'b01, 0, 32'h11, 0); repeat (3) @(negedge clk);

        issue(1, 2'b10, 0, 32'h18, 32'hCAFEBABE); repeat (3) @(negedge clk);
        issue(1, 2'b00, 0, 32'h1B, 32'h00000077); repeat (4) @(negedge clk);
        issue(0, 2'b11, 0, 32'h18, 0); repeat (3) @(negedge clk);
        chk("lw_size3", got_ld, 32'h77FEBABE);
        issue(0, 2'b00, 0, 32'h1A, 0); repeat (3) @(negedge clk);
        issue(0, 2'b01, 0, 32'h1A, 0); repeat (3) @(negedge clk);

        w0 = n_wr; r0 = n_resp;
        sv = mm[16];
        issue(1, 2'b00, 0, 32'h10, 32'h000000EE);
        #1 reset = 1;
        #1;
        chk("rst_mid_busy", 32'(bus.busy), 0);
        chk("rst_mid_resp", 32'(bus.resp_valid), 0);
        chk("rst_mid_mem_write", 32'(bus.mem_write), 0);
        chk("rst_mid_mem_addr", bus.mem_addr, 0);
        for (int k = cyc; k < 1024; k++) begin
            exp_busy[k] = 0; exp_resp[k] = 0; exp_exc[k] = 0; exp_wr[k] = 0;
        end
        free_edge = 0;
        mm[16] = sv;
        repeat (2) @(negedge clk);
        reset = 0;
        repeat (3) @(negedge clk);
        chk("rst_mid_mem", dmem[4], 32'h5566C3D4);
        chk("rst_mid_writes", 32'(n_wr - w0), 0);
        chk("rst_mid_resps", 32'(n_resp - r0), 0);

        r0 = n_resp;
        issue(0, 2'b10, 0, 32'h14, 0);
        issue(0, 2'b10, 0, 32'h10, 0);
        chk("b2b_first", got_ld, 32'h0BADF00D);
        issue(0, 2'b10, 0, 32'h18, 0); repeat (3) @(negedge clk);
        chk("b2b_third", got_ld, 32'h77FEBABE);
        chk("b2b_resps", 32'(n_resp - r0), 2);
        chk("b2b_latency", 32'(got_edge - acc_edge + 1), 2);

        for (int w = 0; w < 8; w++)
            chk("mem_final", dmem[w], {mm[4 * w + 3], mm[4 * w + 2], mm[4 * w + 1], mm[4 * w]});
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
